// File: rtl/dac_sample_scheduler.sv
// Paces producer samples into the DAC datapath: a small FIFO, one release per OSR clocks,
// sticky underrun, and click-free ramps between midscale and the stream on enable/disable.
module dac_sample_scheduler #(
  parameter int DATA_W     = 8,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_STEP  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  input  logic                          clear_underrun,
  output logic [DATA_W-1:0]             dac_data,
  output logic                          dac_load,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]   STEP_X  = (DATA_W+1)'(RAMP_STEP);
  localparam logic [CW-1:0]     CNT_TOP = CW'(OSR - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RUN       = 2'b10,
    RAMP_DOWN = 2'b11
  } state_t;

  // Move cur one ramp step toward tgt in widened unsigned math, landing exactly on tgt when close.
  function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] tgt);
    logic [DATA_W:0] c;
    logic [DATA_W:0] t;
    logic [DATA_W:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (c < t) begin
      if ((t - c) <= STEP_X) r = t;
      else                   r = c + STEP_X;
    end else begin
      if ((c - t) <= STEP_X) r = t;
      else                   r = c - STEP_X;
    end
    return r[DATA_W-1:0];
  endfunction

  state_t              state_r, state_n;
  logic [DATA_W-1:0]   dac_r, dac_n;
  logic                load_r, load_n;
  logic                urun_r;
  logic [CW-1:0]       cnt_r;
  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]       level_r;

  logic                tick_s, full_s, empty_s, flush_s, push_s, pop_s, urun_set_s;
  logic [DATA_W-1:0]   head_s, up_step_s, down_step_s;

  assign tick_s      = (state_r != IDLE) && (cnt_r == CNT_TOP);
  assign full_s      = (level_r == LW'(FIFO_DEPTH));
  assign empty_s     = (level_r == {LW{1'b0}});
  assign flush_s     = (state_r == IDLE) && !enable;
  assign s_ready     = reset && !full_s && !flush_s;
  assign push_s      = s_valid && s_ready;
  assign head_s      = mem_r[rd_ptr_r];
  assign up_step_s   = step_toward(dac_r, head_s);
  assign down_step_s = step_toward(dac_r, MID);

  assign dac_data   = dac_r;
  assign dac_load   = load_r;
  assign underrun   = urun_r;
  assign fifo_level = level_r;
  assign state      = state_r;

  // Tick divider: free-runs only outside IDLE so the first release lands OSR clocks after start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt_r <= {CW{1'b0}};
    else if (state_r == IDLE)   cnt_r <= {CW{1'b0}};
    else if (tick_s)            cnt_r <= {CW{1'b0}};
    else                        cnt_r <= cnt_r + CW'(1);
  end

  // Sample storage; contents are qualified by the level counter so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= s_data;
  end

  // FIFO pointers and occupancy, flushed whenever the block is parked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Next-state and tick-time output decisions; a disable on a tick is served as a ramp-down step.
  always_comb begin
    state_n    = state_r;
    dac_n      = dac_r;
    load_n     = 1'b0;
    pop_s      = 1'b0;
    urun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        dac_n = MID;
        if (enable) state_n = RAMP_UP;
        else        state_n = IDLE;
      end
      RAMP_UP, RUN: begin
        if (!enable) begin
          if (tick_s) begin
            load_n = 1'b1;
            dac_n  = down_step_s;
            if (down_step_s == MID) state_n = IDLE;
            else                    state_n = RAMP_DOWN;
          end else begin
            state_n = RAMP_DOWN;
          end
        end else if (tick_s) begin
          load_n = 1'b1;
          if (empty_s) begin
            urun_set_s = (state_r == RUN);
          end else if (state_r == RUN) begin
            pop_s = 1'b1;
            dac_n = head_s;
          end else begin
            dac_n = up_step_s;
            if (up_step_s == head_s) begin
              pop_s   = 1'b1;
              state_n = RUN;
            end else begin
              state_n = RAMP_UP;
            end
          end
        end else begin
          state_n = state_r;
        end
      end
      RAMP_DOWN: begin
        if (tick_s) begin
          load_n = 1'b1;
          dac_n  = down_step_s;
          if (down_step_s == MID) state_n = IDLE;
          else                    state_n = RAMP_DOWN;
        end else begin
          state_n = RAMP_DOWN;
        end
      end
      default: begin
        state_n = IDLE;
        dac_n   = MID;
      end
    endcase
  end

  // Registered control state and DAC-facing outputs; a new underrun wins over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      dac_r   <= MID;
      load_r  <= 1'b0;
      urun_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      dac_r   <= dac_n;
      load_r  <= load_n;
      if (urun_set_s)          urun_r <= 1'b1;
      else if (clear_underrun) urun_r <= 1'b0;
      else                     urun_r <= urun_r;
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: expected DAC values are queued as stimulus is
// driven and compared on every dac_load; control outputs are compared at fixed points.
module tb_dac_sample_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       clear_underrun;
  logic [7:0] dac_data;
  logic       dac_load;
  logic       underrun;
  logic [2:0] fifo_level;
  logic [1:0] state;

  int         checks_cnt = 0;
  int         errors_cnt = 0;
  int         cyc_cnt = 0;
  int         last_load_cyc = 0;
  logic [7:0] sb [$];

  dac_sample_scheduler #(.DATA_W(8), .OSR(4), .FIFO_DEPTH(4), .RAMP_STEP(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .clear_underrun(clear_underrun), .dac_data(dac_data),
    .dac_load(dac_load), .underrun(underrun), .fifo_level(fifo_level), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && dac_load) begin
      if (sb.size() == 0) chk("unexpected_load", dac_load, 1'b0);
      else                chk("dac_data", dac_data, sb.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_load(output int gap);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dac_load && n < 50);
    chk("load_seen", dac_load, 1'b1);
    gap = cyc_cnt - last_load_cyc;
    last_load_cyc = cyc_cnt;
  endtask

  initial begin
    int gap;
    int accepted;
    int n;

    // Reset held with a valid producer: everything parked.
    reset = 1'b0; enable = 1'b0; s_valid = 1'b1; s_data = 8'h55; clear_underrun = 1'b0;
    step(2);
    chk("rst_dac", dac_data, 8'h80);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_state", state, 2'b00);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_load", dac_load, 1'b0);
    chk("rst_urun", underrun, 1'b0);
    reset = 1'b1;
    step(3);
    chk("idle_dac", dac_data, 8'h80);
    chk("idle_ready", s_ready, 1'b0);
    chk("idle_state", state, 2'b00);
    chk("idle_level", fifo_level, 3'd0);
    s_valid = 1'b0;

    // Ramp up from midscale to the first sample 0x84.
    enable = 1'b1; s_valid = 1'b1; s_data = 8'h84;
    sb.push_back(8'h81); sb.push_back(8'h82); sb.push_back(8'h83); sb.push_back(8'h84);
    step(1);
    s_valid = 1'b0;
    last_load_cyc = cyc_cnt;
    chk("rampup_state", state, 2'b01);
    chk("rampup_level", fifo_level, 3'd1);
    for (int i = 0; i < 4; i++) begin
      wait_load(gap);
      chk("ramp_gap", gap, 4);
    end
    chk("run_state", state, 2'b10);
    chk("run_level", fifo_level, 3'd0);
    chk("run_urun", underrun, 1'b0);

    // Streaming three samples pushed right after a tick.
    s_valid = 1'b1;
    s_data = 8'h10; sb.push_back(8'h10); step(1);
    s_data = 8'h20; sb.push_back(8'h20); step(1);
    s_data = 8'h30; sb.push_back(8'h30); step(1);
    s_valid = 1'b0;
    chk("stream_level", fifo_level, 3'd3);
    for (int i = 0; i < 3; i++) begin
      wait_load(gap);
      chk("stream_gap", gap, 4);
    end

    // Underrun holds the last value; clear loses to a coincident set.
    sb.push_back(8'h30);
    wait_load(gap);
    chk("urun_gap", gap, 4);
    chk("urun_set", underrun, 1'b1);
    step(3);
    clear_underrun = 1'b1;
    sb.push_back(8'h30);
    wait_load(gap);
    clear_underrun = 1'b0;
    chk("urun_set_wins", underrun, 1'b1);
    clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;
    chk("urun_cleared", underrun, 1'b0);

    // Push and pop on the same tick edge keeps the level.
    s_valid = 1'b1; s_data = 8'h84; sb.push_back(8'h84);
    step(1);
    s_valid = 1'b0;
    step(1);
    chk("lvl_before_pp", fifo_level, 3'd1);
    s_valid = 1'b1; s_data = 8'h90;
    wait_load(gap);
    s_valid = 1'b0;
    chk("pp_gap", gap, 4);
    chk("lvl_after_pp", fifo_level, 3'd1);

    // Disable: ramp down to midscale, filling the FIFO on the way (no pops while ramping down).
    enable = 1'b0;
    sb.push_back(8'h83); sb.push_back(8'h82); sb.push_back(8'h81); sb.push_back(8'h80);
    step(1);
    chk("down_state", state, 2'b11);
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hA0 + 8'(i);
      if (s_ready) accepted++;
      step(1);
    end
    s_valid = 1'b0;
    chk("full_accepted", accepted, 3);
    chk("full_level", fifo_level, 3'd4);
    chk("full_ready", s_ready, 1'b0);
    n = 0;
    while (state != 2'b00 && n < 200) begin
      step(1);
      n++;
    end
    chk("down_idle", state, 2'b00);
    chk("down_dac", dac_data, 8'h80);
    step(1);
    chk("flush_level", fifo_level, 3'd0);
    chk("flush_ready", s_ready, 1'b0);
    chk("down_sb_empty", sb.size(), 0);

    // Second ramp up, then asynchronous reset between clock edges while running.
    enable = 1'b1; s_valid = 1'b1; s_data = 8'h82;
    sb.push_back(8'h81); sb.push_back(8'h82);
    step(1);
    s_valid = 1'b0;
    last_load_cyc = cyc_cnt;
    for (int i = 0; i < 2; i++) begin
      wait_load(gap);
      chk("ramp2_gap", gap, 4);
    end
    chk("run2_state", state, 2'b10);
    s_valid = 1'b1; s_data = 8'h40;
    step(1);
    s_valid = 1'b0;
    chk("run2_level", fifo_level, 3'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", state, 2'b00);
    chk("arst_dac", dac_data, 8'h80);
    chk("arst_load", dac_load, 1'b0);
    chk("arst_level", fifo_level, 3'd0);
    chk("arst_ready", s_ready, 1'b0);
    chk("arst_urun", underrun, 1'b0);
    enable = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    chk("post_state", state, 2'b00);
    chk("post_dac", dac_data, 8'h80);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Sequences sample delivery into the interpolating filter / sigma-delta modulator datapath.
- Buffers incoming samples from a valid/ready producer in a small FIFO.
- Releases one sample every OSR clocks and flags underruns.
- Ramps the DAC input to and from midscale on enable/disable so the analog output starts and stops without clicks.

Parameters:
- DATA_W, 8: sample width, offset-binary; midscale MID = 2^(DATA_W-1).
- OSR, 64: clock cycles per output sample (>=2).
- FIFO_DEPTH, 4: sample FIFO entries (power of 2, >=2).
- RAMP_STEP, 1: LSB step per tick during ramps (>=1, < MID).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = play, 0 = ramp down and stop
- s_valid  in  1  producer sample valid
- s_data  in  DATA_W  producer sample
- s_ready  out  1  FIFO can accept
- clear_underrun  in  1  clears sticky underrun flag
- dac_data  out  DATA_W  sample to filter dataIn
- dac_load  out  1  one-cycle pulse, coincident with each dac_data update tick
- underrun  out  1  sticky underrun flag
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- state  out  2  00 IDLE, 01 RAMP_UP, 10 RUN, 11 RAMP_DOWN

Behaviour:
- Reset (reset=0, asynchronous; takes effect immediately, including mid-operation):
  - state=IDLE, dac_data=MID, dac_load=0, underrun=0, FIFO empty, fifo_level=0, s_ready=0, tick counter=0.
- Tick counter:
  - Counts 0..OSR-1 while state!=IDLE; tick = (count==OSR-1), then wraps to 0.
  - Held at 0 in IDLE.
  - First tick occurs OSR cycles after leaving IDLE.
- FIFO:
  - Synchronous, no bypass; a sample pushed in cycle N is poppable from N+1.
  - s_ready = !full && !(state==IDLE && !enable).
  - Push when s_valid && s_ready; pop only on tick as defined per state.
  - Push and pop in the same cycle leaves level unchanged.
  - In IDLE with enable=0 the FIFO is flushed (level forced 0).
- dac_data/dac_load:
  - Registered; change only on a tick.
  - dac_load=1 on every tick in non-IDLE states, even if the value is unchanged.
- Arithmetic:
  - Comparisons and steps in DATA_W+1-bit unsigned; no wrap.
  - Step results clamp at the target.
- IDLE:
  - dac_data=MID.
  - enable=1 -> RAMP_UP next cycle.
- RAMP_UP, on tick:
  - FIFO empty: hold dac_data; no underrun flag.
  - Else, if |head - dac_data| <= RAMP_STEP: dac_data<=head, pop, ->RUN.
  - Else dac_data moves RAMP_STEP toward head; no pop.
  - enable=0 at any cycle -> RAMP_DOWN; a coincident tick is handled by RAMP_DOWN rules.
- RUN, on tick:
  - FIFO non-empty: pop, dac_data<=head.
  - FIFO empty: hold last dac_data, underrun<=1.
  - enable=0 -> RAMP_DOWN (same rule as RAMP_UP).
- RAMP_DOWN, on tick:
  - If |dac_data - MID| <= RAMP_STEP: dac_data<=MID, ->IDLE.
  - Else step RAMP_STEP toward MID.
  - No pops; pushes still accepted while not full.
  - enable re-asserted does not abort; the block reaches IDLE, then re-enters RAMP_UP next cycle.
- underrun:
  - Set has priority over clear_underrun in the same cycle.
  - Cleared only by clear_underrun or reset.

Test Plan (OSR=4, FIFO_DEPTH=4, RAMP_STEP=1, DATA_W=8):
1. Reset: hold reset=0, s_valid=1 -> dac_data=0x80, s_ready=0, state=00, fifo_level=0, dac_load=0. Release with enable=0 -> outputs unchanged.
2. Ramp up: enable=1, push 0x84 -> state 01. dac_data reads 0x81, 0x82, 0x83 on successive ticks (every 4 clocks, dac_load each), then 0x84 with state=10, fifo_level=0, underrun=0.
3. Streaming: in RUN, push 0x10, 0x20, 0x30 back-to-back -> fifo_level=3. Next three ticks give dac_data 0x10, 0x20, 0x30, with exactly one dac_load per tick and 4-cycle spacing.
4. Underrun: RUN with an empty FIFO -> dac_data holds 0x30 and underrun=1 at the tick. Assert clear_underrun on the next tick cycle with the FIFO still empty -> underrun stays 1. Clear on a non-tick cycle -> 0.
5. Full / simultaneous: with no tick pending, push 5 samples -> s_ready falls after the 4th and fifo_level=4. Push and pop coinciding on a tick -> level unchanged.
6. Disable and async reset: at dac_data=0x84, enable=0 -> 0x83, 0x82, 0x81, 0x80 on ticks, then state=00 with the FIFO flushed. Repeat, asserting reset mid-RUN between clock edges -> outputs take reset values immediately.
